// File: rtl/cpu_types_pkg.sv
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU types for the pipeline controller: pipeline
//               control state, register number type and bundled control word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  localparam int c_REG_W = 5;

  typedef logic [c_REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
  } pipe_ctrl_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
// ============================================================================
// Module      : pipeline_ctrl_if
// Description : Groups the pipeline advance/flush enables and the halt flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_ctrl_if;
  logic pc_en;
  logic ifid_en;
  logic idex_en;
  logic exmem_en;
  logic memwb_en;
  logic ifid_flush;
  logic idex_flush;
  logic exmem_flush;
  logic halt;
endinterface

`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use compare between the EX-stage load
//               destination and the ID-stage source registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     i_ex_memread,
  input  regbits_t i_ex_rt,
  input  regbits_t i_id_rs,
  input  regbits_t i_id_rt,
  output logic     o_load_use
);

  // $zero is never a real dependency
  assign o_load_use = i_ex_memread && (i_ex_rt != '0) &&
                      ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module      : pipeline_ctrl
// Description : Five-stage pipeline stall/flush/halt controller.
//               Optional macro PIPE_PERF_EN adds stall/flush event counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2
)
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic       ihit,
  input  logic       dmemREN,
  input  logic       dmemWEN,
  input  logic       dhit,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       ex_branch_taken,
  input  logic       id_jump,
  input  logic       mem_halt,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic       halt
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  localparam int c_CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_DRAIN_LOAD = c_CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

  pipe_state_t        r_state;
  pipe_state_t        w_next_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_next_cnt;
  logic               r_halt;
  logic               w_mem_busy;
  logic               w_load_use;
  logic               w_branch;
  pipe_ctrl_t         w_ctrl;

  pipeline_ctrl_if u_ctrl_if ();

  hazard_detect u_hazard_detect (
    .i_ex_memread (ex_memread),
    .i_ex_rt      (ex_rt),
    .i_id_rs      (id_rs),
    .i_id_rt      (id_rt),
    .o_load_use   (w_load_use)
  );

  assign w_mem_busy = (dmemREN | dmemWEN) & ~dhit;
  // A branch behind a halting instruction is younger and must not redirect
  assign w_branch   = ex_branch_taken & ~mem_halt;

  always_comb begin
    w_ctrl       = '0;
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      RUN: begin
        if (!w_mem_busy) begin
          w_ctrl.idex_en  = 1'b1;
          w_ctrl.exmem_en = 1'b1;
          w_ctrl.memwb_en = 1'b1;
          if (w_branch) begin
            w_ctrl.pc_en      = 1'b1;
            w_ctrl.ifid_en    = 1'b1;
            w_ctrl.ifid_flush = 1'b1;
            w_ctrl.idex_flush = 1'b1;
          end else if (w_load_use || !ihit) begin
            w_ctrl.idex_flush = 1'b1;
          end else if (id_jump) begin
            w_ctrl.pc_en      = 1'b1;
            w_ctrl.ifid_en    = 1'b1;
            w_ctrl.ifid_flush = 1'b1;
          end else begin
            w_ctrl.pc_en   = ihit;
            w_ctrl.ifid_en = ihit;
          end
          if (mem_halt) begin
            w_next_state = DRAIN;
            w_next_cnt   = c_DRAIN_LOAD;
          end
        end
      end
      DRAIN: begin
        w_ctrl.ifid_flush  = 1'b1;
        w_ctrl.idex_flush  = 1'b1;
        w_ctrl.exmem_flush = 1'b1;
        w_ctrl.memwb_en    = 1'b1;
        if (r_cnt == '0) begin
          w_next_state = HALTED;
        end else begin
          w_next_cnt = r_cnt - c_CNT_ONE;
        end
      end
      HALTED: begin
        w_next_state = HALTED;
      end
      default: begin
        w_next_state = RUN;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_halt  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_next_state == HALTED) begin
        r_halt <= 1'b1;
      end
    end
  end

  // Every enable and flush is held low while reset is asserted
  assign u_ctrl_if.pc_en       = nRST & w_ctrl.pc_en;
  assign u_ctrl_if.ifid_en     = nRST & w_ctrl.ifid_en;
  assign u_ctrl_if.idex_en     = nRST & w_ctrl.idex_en;
  assign u_ctrl_if.exmem_en    = nRST & w_ctrl.exmem_en;
  assign u_ctrl_if.memwb_en    = nRST & w_ctrl.memwb_en;
  assign u_ctrl_if.ifid_flush  = nRST & w_ctrl.ifid_flush;
  assign u_ctrl_if.idex_flush  = nRST & w_ctrl.idex_flush;
  assign u_ctrl_if.exmem_flush = nRST & w_ctrl.exmem_flush;
  assign u_ctrl_if.halt        = r_halt;

  assign pc_en       = u_ctrl_if.pc_en;
  assign ifid_en     = u_ctrl_if.ifid_en;
  assign idex_en     = u_ctrl_if.idex_en;
  assign exmem_en    = u_ctrl_if.exmem_en;
  assign memwb_en    = u_ctrl_if.memwb_en;
  assign ifid_flush  = u_ctrl_if.ifid_flush;
  assign idex_flush  = u_ctrl_if.idex_flush;
  assign exmem_flush = u_ctrl_if.exmem_flush;
  assign halt        = u_ctrl_if.halt;

`ifdef PIPE_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else if (r_state == RUN) begin
      if (!w_ctrl.pc_en) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_ctrl.ifid_flush) begin
        r_flush_events <= r_flush_events + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed self-checking bench for pipeline_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       ihit, dmemREN, dmemWEN, dhit;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_memread, ex_branch_taken, id_jump, mem_halt;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_flush, exmem_flush, halt;
`ifdef PIPE_PERF_EN
  logic [31:0] stall_cycles, flush_events;
`endif
  logic [7:0] ctrl;

  int checks = 0;
  int fails  = 0;

  always #5 CLK = ~CLK;

  assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush};

  pipeline_ctrl #(.DRAIN_CYCLES(2)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dhit(dhit), .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread),
    .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .id_jump(id_jump),
    .mem_halt(mem_halt), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .halt(halt)
`ifdef PIPE_PERF_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  task automatic idle();
    ihit = 1'b1; dmemREN = 1'b0; dmemWEN = 1'b0; dhit = 1'b0;
    id_rs = 5'd1; id_rt = 5'd2; ex_rt = 5'd3; ex_memread = 1'b0;
    ex_branch_taken = 1'b0; id_jump = 1'b0; mem_halt = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    idle();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    nRST = 1'b0;
    idle();
    #1;
    checks++;
    if (ctrl !== 8'h00 || halt !== 1'b0) begin
      fails++; $display("FAIL reset_outputs: got ctrl=%b halt=%b want ctrl=00000000 halt=0", ctrl, halt);
    end
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    checks++;
    if (ctrl !== 8'b11111000) begin
      fails++; $display("FAIL run_normal: got %b want 11111000", ctrl);
    end
  endtask

  task automatic test_miss();
    @(negedge CLK);
    idle(); ihit = 1'b0;
    #1;
    checks++;
    if ({pc_en, ifid_en, idex_flush, idex_en, exmem_en, memwb_en} !== 6'b001111) begin
      fails++; $display("FAIL imiss: got %b want 001111", {pc_en, ifid_en, idex_flush, idex_en, exmem_en, memwb_en});
    end
  endtask

  task automatic test_load_use();
    @(negedge CLK);
    idle(); ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd7;
    #1;
    checks++;
    if ({pc_en, ifid_en, idex_flush} !== 3'b001) begin
      fails++; $display("FAIL lu_rs: got %b want 001", {pc_en, ifid_en, idex_flush});
    end
    @(negedge CLK);
    ex_memread = 1'b0;
    #1;
    checks++;
    if ({pc_en, ifid_en, idex_flush} !== 3'b110) begin
      fails++; $display("FAIL lu_release: got %b want 110", {pc_en, ifid_en, idex_flush});
    end
    @(negedge CLK);
    ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1;
    checks++;
    if ({pc_en, ifid_en, idex_flush} !== 3'b110) begin
      fails++; $display("FAIL lu_zero_reg: got %b want 110", {pc_en, ifid_en, idex_flush});
    end
    @(negedge CLK);
    ex_rt = 5'd9; id_rs = 5'd1; id_rt = 5'd9;
    #1;
    checks++;
    if ({pc_en, ifid_en, idex_flush} !== 3'b001) begin
      fails++; $display("FAIL lu_rt: got %b want 001", {pc_en, ifid_en, idex_flush});
    end
    @(negedge CLK);
    ex_rt = 5'd9; id_rs = 5'd8; id_rt = 5'd10;
    #1;
    checks++;
    if ({pc_en, ifid_en, idex_flush} !== 3'b110) begin
      fails++; $display("FAIL lu_nomatch: got %b want 110", {pc_en, ifid_en, idex_flush});
    end
  endtask

  task automatic test_branch();
    @(negedge CLK);
    idle(); ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; ex_branch_taken = 1'b1;
    #1;
    checks++;
    if ({ifid_flush, idex_flush, pc_en} !== 3'b111) begin
      fails++; $display("FAIL branch_over_lu: got %b want 111", {ifid_flush, idex_flush, pc_en});
    end
    @(negedge CLK);
    idle(); id_jump = 1'b1; ex_branch_taken = 1'b1;
    #1;
    checks++;
    if ({ifid_flush, idex_flush, pc_en} !== 3'b111) begin
      fails++; $display("FAIL branch_over_jump: got %b want 111", {ifid_flush, idex_flush, pc_en});
    end
  endtask

  task automatic test_jump();
    @(negedge CLK);
    idle(); id_jump = 1'b1;
    #1;
    checks++;
    if ({ifid_flush, pc_en, idex_flush} !== 3'b110) begin
      fails++; $display("FAIL jump: got %b want 110", {ifid_flush, pc_en, idex_flush});
    end
    @(negedge CLK);
    idle(); id_jump = 1'b1; ex_memread = 1'b1; ex_rt = 5'd4; id_rt = 5'd4;
    #1;
    checks++;
    if ({pc_en, ifid_en, idex_flush, ifid_flush} !== 4'b0010) begin
      fails++; $display("FAIL lu_over_jump: got %b want 0010", {pc_en, ifid_en, idex_flush, ifid_flush});
    end
  endtask

  task automatic test_freeze();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      idle(); dmemREN = 1'b1; dhit = 1'b0; ex_branch_taken = 1'b1;
      #1;
      checks++;
      if (ctrl !== 8'h00) begin
        fails++; $display("FAIL freeze_c%0d: got %b want 00000000", i, ctrl);
      end
    end
    @(negedge CLK);
    dhit = 1'b1;
    #1;
    checks++;
    if ({ifid_flush, idex_flush, pc_en, exmem_en, memwb_en} !== 5'b11111) begin
      fails++; $display("FAIL freeze_release: got %b want 11111", {ifid_flush, idex_flush, pc_en, exmem_en, memwb_en});
    end
    @(negedge CLK);
    idle(); dmemWEN = 1'b1; dhit = 1'b0;
    #1;
    checks++;
    if (ctrl !== 8'h00) begin
      fails++; $display("FAIL freeze_write: got %b want 00000000", ctrl);
    end
  endtask

  task automatic test_halt();
    @(negedge CLK);
    idle(); mem_halt = 1'b1; ex_branch_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      idle();
      #1;
      checks++;
      if ({pc_en, memwb_en, ifid_flush, idex_flush, exmem_flush, halt} !== 6'b011110) begin
        fails++; $display("FAIL drain_c%0d: got %b want 011110", i, {pc_en, memwb_en, ifid_flush, idex_flush, exmem_flush, halt});
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      ihit = i[0];
      #1;
      checks++;
      if (ctrl !== 8'h00 || halt !== 1'b1) begin
        fails++; $display("FAIL halted_c%0d: got ctrl=%b halt=%b want ctrl=00000000 halt=1", i, ctrl, halt);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    @(negedge CLK);
    mem_halt = 1'b1;
    @(negedge CLK);
    mem_halt = 1'b0;
    #2;
    nRST = 1'b0;
    #1;
    checks++;
    if (ctrl !== 8'h00 || halt !== 1'b0) begin
      fails++; $display("FAIL drain_reset: got ctrl=%b halt=%b want ctrl=00000000 halt=0", ctrl, halt);
    end
    @(negedge CLK);
    nRST = 1'b1; idle();
    #1;
    checks++;
    if (ctrl !== 8'b11111000 || halt !== 1'b0) begin
      fails++; $display("FAIL drain_reset_run: got ctrl=%b halt=%b want ctrl=11111000 halt=0", ctrl, halt);
    end
    @(negedge CLK);
    ihit = 1'b0;
    #1;
    checks++;
    if ({pc_en, exmem_flush} !== 2'b00) begin
      fails++; $display("FAIL drain_reset_miss: got %b want 00", {pc_en, exmem_flush});
    end
  endtask

`ifdef PIPE_PERF_EN
  task automatic test_perf();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      idle(); ihit = 1'b0;
    end
    @(negedge CLK);
    idle(); id_jump = 1'b1;
    @(negedge CLK);
    idle();
    #1;
    checks++;
    if (stall_cycles !== 32'd4 || flush_events !== 32'd1) begin
      fails++; $display("FAIL perf_counters: got stall=%0d flush=%0d want stall=4 flush=1", stall_cycles, flush_events);
    end
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_miss();
    test_load_use();
    test_branch();
    test_jump();
    test_freeze();
    test_halt();
    test_reset_mid_drain();
`ifdef PIPE_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named CLK and nRST.
REQ-002 Port: CLK  in  1  rising-edge clock.
REQ-003 Port: nRST  in  1  asynchronous active-low reset.
REQ-004 Port: ihit  in  1  instruction fetch returned this cycle.
REQ-005 Port: dmemREN, dmemWEN  in  1 each  MEM-stage data access request.
REQ-006 Port: dhit  in  1  data access completes this cycle.
REQ-007 Port: id_rs, id_rt  in  5 each  ID-stage source register numbers.
REQ-008 Port: ex_memread  in  1  EX-stage instruction is a load.
REQ-009 Port: ex_rt  in  5  EX-stage load destination register.
REQ-010 Port: ex_branch_taken  in  1  EX resolved a taken branch.
REQ-011 Port: id_jump  in  1  ID decoded J/JAL/JR.
REQ-012 Port: mem_halt  in  1  HALT instruction is in the MEM stage.
REQ-013 Port: pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register/latch advance enables.
REQ-014 Port: ifid_flush, idex_flush, exmem_flush  out  1 each  load-bubble (zero) into that latch.
REQ-015 Port: halt  out  1  registered, sticky processor-halted flag.
REQ-016 Parameter: DRAIN_CYCLES, default 2, number of cycles spent in DRAIN before HALTED.

Function
REQ-017 The block SHALL define mem_busy = (dmemREN | dmemWEN) & ~dhit.
REQ-018 The block SHALL implement an FSM with states RUN, DRAIN and HALTED, plus a drain counter that is $clog2(DRAIN_CYCLES+1) bits wide.
REQ-019 In RUN with mem_busy, the block SHALL drive all enables to 0 and all flushes to 0 (full freeze); freeze SHALL take priority over every other rule.
REQ-020 In RUN without mem_busy, the block SHALL drive exmem_en=1, memwb_en=1 and idex_en=1.
REQ-021 Taken branch (ex_branch_taken=1, no freeze): the block SHALL drive ifid_flush=1, idex_flush=1 and pc_en=1; this SHALL override load-use and jump handling.
REQ-022 Load-use hazard (ex_memread & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt), no branch): the block SHALL drive pc_en=0, ifid_en=0 and idex_flush=1 for exactly as long as the condition holds.
REQ-023 Jump (id_jump=1, no branch, no load-use): the block SHALL drive ifid_flush=1 and pc_en=1.
REQ-024 Instruction miss (ihit=0, no higher-priority rule): the block SHALL drive pc_en=0, ifid_en=0 and idex_flush=1, so that no instruction is duplicated.
REQ-025 Otherwise in RUN, the block SHALL drive pc_en=ihit and ifid_en=ihit; flushes SHALL take effect only when the corresponding enable path is not frozen.
REQ-026 Transition RUN->DRAIN: when mem_halt=1 and ~mem_busy, the counter SHALL load DRAIN_CYCLES-1.
REQ-027 In DRAIN, the block SHALL drive pc_en=0, ifid_flush=1, idex_flush=1, exmem_flush=1 and memwb_en=1, and the counter SHALL decrement each cycle.
REQ-028 Transition DRAIN->HALTED: when the counter is 0.
REQ-029 In HALTED, all enables and flushes SHALL be 0 and halt SHALL be 1; HALTED SHALL persist until reset.
REQ-030 Simultaneous mem_halt and ex_branch_taken: the RUN->DRAIN transition SHALL win, because the branch is younger.

Reset
REQ-031 On nRST=0, the state SHALL go to RUN, the counter to 0 and halt to 0, asynchronously.
REQ-032 During reset, all enables and flushes SHALL be 0; reset asserted during DRAIN or HALTED SHALL return the block to RUN.

Configuration
REQ-033 With PIPE_PERF_EN defined, the block SHALL add outputs stall_cycles[31:0] (counts cycles where pc_en=0 in RUN) and flush_events[31:0] (counts cycles where ifid_flush=1 in RUN); both SHALL wrap at 2^32 and reset to 0.
REQ-034 Without PIPE_PERF_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-035 The state enum (pipe_state_t) and regbits_t SHALL live in cpu_types_pkg.
REQ-036 The outputs SHALL be grouped in a pipeline_ctrl_if interface.
REQ-037 A combinational sub-module, hazard_detect (load-use compare), is natural and SHALL be instantiated once.

Verification
REQ-038 Load-use: ex_memread=1, ex_rt=5, id_rs=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1 for one cycle; with ex_rt=0 -> no stall.
REQ-039 Branch and load-use together: ex_branch_taken=1 with a load-use match -> ifid_flush=1, idex_flush=1, pc_en=1.
REQ-040 Freeze: dmemREN=1, dhit=0 for 3 cycles with ex_branch_taken=1 -> all outputs 0 for 3 cycles; branch flush on the cycle dhit=1.
REQ-041 Halt: mem_halt=1 with DRAIN_CYCLES=2 -> DRAIN for 2 cycles, then halt=1 and stays; a later ihit toggle has no effect.
REQ-042 Reset mid-DRAIN: nRST low in DRAIN cycle 1 -> halt=0, state RUN, pc_en follows ihit after release.
REQ-043 PIPE_PERF_EN: 4 miss cycles plus 1 jump -> stall_cycles=4, flush_events=1.
